// File: rtl/serial16_tx.sv
// serial16_tx: 16-bit parallel-to-serial transmitter with valid/ready on both sides.
// Optional even-parity trailer beat when SERIAL16_PARITY_EN is defined.
module serial16_tx #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_bit_o,
  output logic        out_last_o,
  output logic [3:0]  sel_o,
  output logic        busy_o
);

`ifdef SERIAL16_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
  localparam bit PARITY_BEAT = 1'b1;

  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
  localparam bit PARITY_BEAT = 1'b0;
`endif

  localparam logic [3:0] SEL_FIRST = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] SEL_TERM  = MSB_FIRST ? 4'd0  : 4'd15;

  state_t      state_q;
  logic [15:0] w_q;
  logic [3:0]  sel_q;
  logic [3:0]  sel_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_bit_q;
  logic        out_last_q;
  logic        busy_q;

  // Index of the next bit to present after an accepted beat.
  always_comb begin
    sel_d = sel_q;
    if (MSB_FIRST) begin
      sel_d = sel_q - 4'd1;
    end else begin
      sel_d = sel_q + 4'd1;
    end
  end

  // Sequencer: every output is registered and updated together with the state.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      w_q         <= 16'h0000;
      sel_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            state_q     <= SHIFT;
            w_q         <= in_data_i;
            sel_q       <= SEL_FIRST;
            out_bit_q   <= in_data_i[SEL_FIRST];
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          if (out_ready_i) begin
            if (sel_q == SEL_TERM) begin
`ifdef SERIAL16_PARITY_EN
              // sel stays at its terminal value while the parity bit is sent
              state_q    <= PARITY;
              out_bit_q  <= even_parity(w_q);
              out_last_q <= 1'b1;
`else
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
`endif
            end else begin
              sel_q      <= sel_d;
              out_bit_q  <= w_q[sel_d];
              out_last_q <= (sel_d == SEL_TERM) && !PARITY_BEAT;
            end
          end
        end
`ifdef SERIAL16_PARITY_EN
        PARITY: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_bit_o   = out_bit_q;
  assign out_last_o  = out_last_q;
  assign sel_o       = sel_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/serial16_tx.md
# serial16_tx

Parallel-to-serial transmitter built around a registered 16-to-1 selection path. It accepts a 16-bit word over a valid/ready handshake and steps a 4-bit select counter through every bit position, presenting one bit per accepted output beat. It sits directly upstream of the 16:1 mux datapath: `sel` and the captured word drive the mux select and data inputs. The block also owns the sequencing and flow control that the plain mux lacks.

## Interface
- `MSB_FIRST`, default 0: 0 sends bit 0 first (`sel` counts 0 to 15); 1 sends bit 15 first (`sel` counts 15 to 0).
- `clk` (input, 1): single clock; all state changes on its rising edge.
- `resetn` (input, 1): synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` (input, 1): `in_data` is offered.
- `in_ready` (output, 1): block can accept a word.
- `in_data` (input, 16): parallel word to serialise.
- `out_valid` (output, 1): `out_bit` is valid.
- `out_ready` (input, 1): downstream accepts `out_bit`.
- `out_bit` (output, 1): current serial bit, equal to `w[sel]` of the captured word.
- `out_last` (output, 1): high with the final beat of a word.
- `sel` (output, 4): current bit index.
- `busy` (output, 1): high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SHIFT, and PARITY. PARITY exists only with the macro described under Configuration.
- **IDLE:**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid` && `in_ready`: capture `in_data` into `w`, set `sel` to 0 (or 15 if `MSB_FIRST`), and go to SHIFT.
- **SHIFT:**
  - `out_valid` = 1, `in_ready` = 0, `out_bit` = `w[sel]`.
  - On `out_valid` && `out_ready`: advance `sel` by one (increment, or decrement if `MSB_FIRST`).
  - On the beat at the terminal index (15, or 0 if `MSB_FIRST`), go to IDLE, or to PARITY if the macro is defined.
  - `sel` never wraps inside a word.
- **Stall:** while `out_ready` = 0, `sel`, `w`, and `out_bit` hold their values.
- `in_valid` is ignored while `busy` is high. A word is never overwritten mid-transfer.
- `out_last` = 1 only in the cycle carrying the final beat of a word: terminal index in SHIFT without the macro, or the PARITY beat with the macro.
- **Reset values** (when `resetn` = 0 at an edge): state IDLE, `w` = 0, `sel` = 0, `out_valid` = 0, `out_last` = 0, `out_bit` = 0, `busy` = 0, `in_ready` = 1 from the following cycle.
- **Reset mid-word:** the transfer is aborted with no further beats, and the rest of the word is discarded.

## Timing
- Load to first bit: `out_valid` rises the cycle after the input handshake, so latency is 1 cycle.
- Throughput: one bit per cycle with `out_ready` held high. A word takes 16 cycles in SHIFT, plus 1 cycle for parity if enabled.
- Return to IDLE: `in_ready` rises the cycle after the last beat is accepted. The minimum word-to-word period is 17 cycles (18 with parity).
- `out_bit`, `out_last`, and `sel` come directly from registers and the captured word. There is no combinational path from `out_ready` to `out_valid`.
- `in_ready` depends only on state and has no combinational path from `in_valid`.

## Configuration
- `SERIAL16_PARITY_EN`
  - **Defined:** after the 16 data beats, the FSM enters PARITY and sends one extra beat.
    - `out_bit` = even parity, i.e. the XOR of all 16 bits of `w`.
    - `out_last` = 1 on that beat.
    - `sel` holds at its terminal value during the PARITY beat.
  - **Undefined:** the PARITY state and parity logic are absent. The transfer is exactly 16 beats, with `out_last` on the 16th.

## Test plan
- **Reset:** hold `resetn` = 0 for 2 cycles with `in_valid` = 1 and `in_data` = 16'hFFFF → `out_valid` = 0, `busy` = 0, `sel` = 0 throughout; `in_ready` = 1 after release.
- **LSB-first stream:** `MSB_FIRST` = 0, load 16'hA5C3, `out_ready` held at 1 → bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles; `out_last` only on the 16th beat; `in_ready` = 1 on the next cycle.
- **MSB-first stream:** `MSB_FIRST` = 1, load 16'h8001 → first beat 1, then 14 zeros, then 1; `sel` runs 15 down to 0.
- **Backpressure:** load 16'h00F0 and drop `out_ready` for 3 cycles at `sel` = 4 → `out_bit` = 1 and `sel` = 4 held for all 3 cycles; the stream resumes with no lost or duplicated bits.
- **Busy ignore and mid-word reset:**
  - During SHIFT, pulse `in_valid` with 16'h1234 → ignored, and the original word completes.
  - Assert `resetn` = 0 at `sel` = 7 → next cycle `out_valid` = 0 and IDLE.
- **Parity** (`SERIAL16_PARITY_EN` defined): load 16'h0007 → 17 beats, with a 17th bit of 1 and `out_last` on it; load 16'h0003 → 17th bit 0.
